// File: rtl/msg_schedule_ctrl.sv
`timescale 1ns/1ps
// SHA-256 message-schedule sequencer: loads one 512-bit block into a 16-word sliding
// window and streams W[0..NUM_WORDS-1] over a valid/ready handshake.
module msg_schedule_ctrl #(
    parameter int NUM_WORDS = 64,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [511:0]     block_in,
    output logic             busy,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_out,
    output logic [IDX_W-1:0] w_idx,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [31:0]      window [16];
    logic [IDX_W-1:0] t;
    logic             xfer;
    logic             last;
    logic             load;
    logic [31:0]      w_next;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign xfer   = w_valid & w_ready;
    assign last   = (t == IDX_W'(NUM_WORDS - 1));
    assign load   = (state == IDLE) & start;
    // W[t+16] from the current window; single-cycle adder path
    assign w_next = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

    assign w_out  = window[0];
    assign w_idx  = t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)       state_nxt = RUN;
            RUN:  if (xfer && last) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        w_valid = 1'b0;
        if (state == RUN) begin
            busy    = 1'b1;
            w_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t    <= '0;
            done <= 1'b0;
            for (int k = 0; k < 16; k++) window[k] <= '0;
        end else begin
            done <= xfer & last;
            if (load) begin
                t <= '0;
                for (int k = 0; k < 16; k++) window[k] <= block_in[511-32*k -: 32];
            end else if (xfer) begin
                t <= t + 1'b1;
                for (int k = 0; k < 15; k++) window[k] <= window[k+1];
                window[15] <= w_next;
            end
        end
    end

endmodule

// File: tb/tb_msg_schedule_ctrl.sv
`timescale 1ns/1ps
// Randomized bench for msg_schedule_ctrl against a direct SHA-256 schedule recurrence model.
module tb_msg_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] block_in;
    logic         busy;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]  exp_w [64];
    logic [511:0] abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
    logic [511:0] ones_blk = {512{1'b1}};
    logic [31:0]  kat [4]  = '{32'h00000018, 32'h61626380, 32'h000F0000, 32'h7DA86405};

    msg_schedule_ctrl #(.NUM_WORDS(64), .IDX_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .block_in (block_in),
        .busy     (busy),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .w_idx    (w_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Standard recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
    function automatic void build_model(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) exp_w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(exp_w[i-15], 7) ^ ror(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
            s1 = ror(exp_w[i-2], 17) ^ ror(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
            exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
        end
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, w_valid, w_out, w_idx, done} !== 41'd0) begin
                miscompares++;
                $display("FAIL reset_hold: busy=%b vld=%b out=%h idx=%0d done=%b, want all 0",
                         busy, w_valid, w_out, w_idx, done);
            end
            start    = 1'($urandom);
            w_ready  = 1'($urandom);
            block_in = rand_block();
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || w_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b vld=%b done=%b, want 0 0 0", busy, w_valid, done);
        end
    endtask

    task automatic test_abc();
        build_model(abc_blk);
        @(negedge clk);
        block_in = abc_blk; start = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; block_in = rand_block();
        for (int idx = 0; idx < 64; idx++) begin
            vectors++;
            if (w_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL abc_ctrl t=%0d: vld=%b busy=%b done=%b, want 1 1 0", idx, w_valid, busy, done);
            end
            vectors++;
            if (w_out !== exp_w[idx] || w_idx !== 6'(idx)) begin
                miscompares++;
                $display("FAIL abc_word t=%0d: got %h idx %0d, want %h idx %0d", idx, w_out, w_idx, exp_w[idx], idx);
            end
            if (idx >= 15 && idx <= 18) begin
                vectors++;
                if (w_out !== kat[idx-15]) begin
                    miscompares++;
                    $display("FAIL abc_kat W[%0d]: got %h, want %h", idx, w_out, kat[idx-15]);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abc_done: done=%b busy=%b vld=%b, want 1 0 0", done, busy, w_valid);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL abc_done_pulse: done=%b, want 0", done);
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cycles = 0;
        build_model(abc_blk);
        @(negedge clk);
        block_in = abc_blk; start = 1'b1; w_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; block_in = rand_block();
        while (idx < 64 && cycles < 2000) begin
            vectors++;
            if (w_valid !== 1'b1 || w_out !== exp_w[idx] || w_idx !== 6'(idx) || done !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_word t=%0d: vld=%b out=%h idx=%0d done=%b, want 1 %h %0d 0",
                         idx, w_valid, w_out, w_idx, done, exp_w[idx], idx);
            end
            w_ready = 1'($urandom);
            @(negedge clk);
            if (w_ready) idx++;
            cycles++;
        end
        vectors++;
        if (idx != 64) begin
            miscompares++;
            $display("FAIL bp_budget: transferred %0d words, want 64", idx);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_done: done=%b busy=%b, want 1 0", done, busy);
        end
        w_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int done_cnt = 0;
        build_model(abc_blk);
        @(negedge clk);
        block_in = abc_blk; start = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int idx = 0; idx < 64; idx++) begin
            vectors++;
            if (w_out !== exp_w[idx] || w_idx !== 6'(idx) || w_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_start_word t=%0d: got %h idx %0d vld %b, want %h idx %0d vld 1",
                         idx, w_out, w_idx, w_valid, exp_w[idx], idx);
            end
            start = (idx == 10);
            if (idx == 10) block_in = rand_block();
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        vectors++;
        if (done_cnt != 1 || w_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_done: %0d done pulses vld=%b, want 1 pulse vld 0", done_cnt, w_valid);
        end
    endtask

    task automatic test_back_to_back();
        build_model(abc_blk);
        @(negedge clk);
        block_in = abc_blk; start = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int idx = 0; idx < 64; idx++) @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_done: done=%b, want 1", done);
        end
        block_in = ones_blk; start = 1'b1;
        build_model(ones_blk);
        @(negedge clk);
        start = 1'b0; block_in = rand_block();
        for (int idx = 0; idx < 64; idx++) begin
            vectors++;
            if (w_valid !== 1'b1 || w_out !== exp_w[idx] || w_idx !== 6'(idx)) begin
                miscompares++;
                $display("FAIL b2b_word t=%0d: vld=%b got %h idx %0d, want %h idx %0d",
                         idx, w_valid, w_out, w_idx, exp_w[idx], idx);
            end
            if (idx == 0) begin
                vectors++;
                if (w_out !== 32'hFFFFFFFF) begin
                    miscompares++;
                    $display("FAIL b2b_w0: got %h, want ffffffff", w_out);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_done: done=%b, want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [511:0] blk;
        blk = rand_block();
        build_model(blk);
        @(negedge clk);
        block_in = blk; start = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int idx = 0; idx < 30; idx++) @(negedge clk);
        vectors++;
        if (w_idx !== 6'd30 || w_out !== exp_w[30]) begin
            miscompares++;
            $display("FAIL mid_rst_pre: got %h idx %0d, want %h idx 30", w_out, w_idx, exp_w[30]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, w_valid, w_out, w_idx, done} !== 41'd0) begin
            miscompares++;
            $display("FAIL mid_rst_async: busy=%b vld=%b out=%h idx=%0d done=%b, want all 0",
                     busy, w_valid, w_out, w_idx, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || w_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_rst_nodone: done=%b vld=%b, want 0 0", done, w_valid);
            end
        end
        blk = rand_block();
        build_model(blk);
        block_in = blk; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int idx = 0; idx < 64; idx++) begin
            vectors++;
            if (w_valid !== 1'b1 || w_out !== exp_w[idx] || w_idx !== 6'(idx)) begin
                miscompares++;
                $display("FAIL mid_rst_fresh t=%0d: vld=%b got %h idx %0d, want %h idx %0d",
                         idx, w_valid, w_out, w_idx, exp_w[idx], idx);
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst_fresh_done: done=%b, want 1", done);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; w_ready = 1'b0; block_in = '0;
        test_reset();
        test_abc();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns, want completion");
        $fatal(1, "timeout");
    end

endmodule
